// File: rtl/granth_crc_engine.sv
// Bit-serial parametrised CRC engine: nibble-wide LOAD, one message bit per clock, nibble readout.
// Optional input queue is enabled by defining CRC_FIFO_EN.
module granth_crc_engine #(
  parameter int               CRC_W      = 16,
  parameter logic [CRC_W-1:0] POLY       = 16'h1021,
  parameter logic [CRC_W-1:0] INIT       = 16'hFFFF,
  parameter logic [CRC_W-1:0] XOROUT     = 16'h0000,
  parameter int               REFIN      = 0,
  parameter int               REFOUT     = 0,
  parameter int               DIN_W      = 4,
  parameter int               FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       cmd,
  input  logic [DIN_W-1:0] data_in,
  output logic [3:0]       data_out,
  output logic             valid,
  output logic             busy,
  output logic             err
);

  localparam int N     = CRC_W / 4;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = (DIN_W > 1) ? $clog2(DIN_W) : 1;

  function automatic logic [CRC_W-1:0] bit_rev(input logic [CRC_W-1:0] v);
    for (int i = 0; i < CRC_W; i++) bit_rev[i] = v[CRC_W-1-i];
  endfunction

  localparam logic [CRC_W-1:0] POLY_R = bit_rev(POLY);

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
    logic fb;
    if (REFIN != 0) begin
      fb       = c[0] ^ b;
      crc_step = (c >> 1) ^ (fb ? POLY_R : '0);
    end else begin
      fb       = c[CRC_W-1] ^ b;
      crc_step = (c << 1) ^ (fb ? POLY : '0);
    end
  endfunction

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [CRC_W-1:0] crc;
  logic [CNT_W-1:0] cnt;
  logic [DIN_W-1:0] din_q;
  logic [IDX_W-1:0] rd_idx;
  logic [CRC_W-1:0] res;
  logic             is_load, is_read, is_init;
  logic             shifting, last_bit, cur_bit;
  logic             start, load_drop;
  logic [DIN_W-1:0] start_data;

  assign is_load  = (cmd == 2'b01);
  assign is_read  = (cmd == 2'b10);
  assign is_init  = (cmd == 2'b11);
  assign shifting = (state_q == SHIFT);
  assign last_bit = shifting && (cnt == '0);
  assign cur_bit  = din_q[(REFIN != 0) ? (DIN_W - 1 - int'(cnt)) : int'(cnt)];

  // A reflected register already holds its value in reflected order, so the
  // readout is mirrored only when the output order differs from the input order.
  assign res = (((REFOUT != 0) != (REFIN != 0)) ? bit_rev(crc) : crc) ^ XOROUT;

`ifdef CRC_FIFO_EN
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DIN_W-1:0] q_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   q_cnt;
  logic             q_empty, q_full, pop, bypass, push;

  assign q_empty    = (q_cnt == '0);
  assign q_full     = (q_cnt == (PTR_W+1)'(FIFO_DEPTH));
  assign busy       = shifting || !q_empty;
  // On the final bit a queued nibble (or a LOAD arriving right then) starts with no idle cycle.
  assign pop        = last_bit && !q_empty;
  assign bypass     = last_bit && q_empty && is_load;
  assign start      = (is_load && !busy) || pop || bypass;
  assign start_data = pop ? q_mem[rd_ptr] : data_in;
  assign push       = is_load && busy && !bypass && !q_full;
  assign load_drop  = is_load && busy && !bypass && q_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= '0;
    end else if (is_init) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   q_cnt <= q_cnt + 1'b1;
        2'b01:   q_cnt <= q_cnt - 1'b1;
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= data_in;
  end
`else
  assign busy       = shifting;
  assign start      = is_load && !shifting;
  assign start_data = data_in;
  assign load_drop  = is_load && shifting;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (is_init)       state_d = IDLE;
    else if (start)    state_d = SHIFT;
    else if (last_bit) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (start) din_q <= start_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc      <= INIT;
      cnt      <= '0;
      data_out <= 4'h0;
      valid    <= 1'b0;
      err      <= 1'b0;
      rd_idx   <= '0;
    end else begin
      valid <= 1'b0;
      if (is_init) begin
        crc    <= INIT;
        rd_idx <= '0;
        err    <= 1'b0;
      end else begin
        if (shifting) begin
          crc <= crc_step(crc, cur_bit);
          cnt <= cnt - 1'b1;
        end
        if (start)   cnt    <= CNT_W'(DIN_W - 1);
        if (is_load) rd_idx <= '0;
        if (load_drop || (is_read && busy)) err <= 1'b1;
        if (is_read && !busy) begin
          data_out <= res[4*(N-1-int'(rd_idx)) +: 4];
          valid    <= 1'b1;
          rd_idx   <= (rd_idx == IDX_W'(N-1)) ? '0 : rd_idx + 1'b1;
        end
      end
    end
  end

endmodule
